// File: rtl/mem_access_stage.sv
// Memory-access stage: one 32-bit load/store as two 16-bit SRAM phases with wait states.
// Optional stall counter enabled by defining MEM_STAGE_PERF_CNT_EN.
module mem_access_stage #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned ADDR_OFFSET = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    input  logic [31:0] ALU_result,
    input  logic [31:0] Val_Rm,
    output logic        freeze,
    output logic        ready,
    output logic [31:0] mem_read_value,
    output logic [17:0] SRAM_ADDR,
    output logic [15:0] SRAM_DQ_out,
    output logic        SRAM_DQ_oe,
    input  logic [15:0] SRAM_DQ_in,
    output logic        SRAM_WE_N,
    output logic        SRAM_OE_N,
    output logic [31:0] stall_cnt
);

    localparam int CW = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        LO,
        HI,
        DONE
    } state_e;

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [16:0]   wa_q;
    logic [15:0]   wdata_hi_q;
    logic          wr_q;
    logic          ready_q;
    logic [31:0]   rdata_q;
    logic [17:0]   addr_q;
    logic [15:0]   dq_out_q;
    logic          dq_oe_q;
    logic          we_n_q;
    logic          oe_n_q;

    logic          req;
    logic          wr_in;
    logic          last;
    logic [16:0]   wa_in;

    // Both enables high resolves to a store.
    assign req   = MEM_R_EN | MEM_W_EN;
    assign wr_in = MEM_W_EN;
    assign wa_in = 17'((ALU_result - ADDR_OFFSET) >> 2);
    assign last  = (cnt_q == CNT_LAST);

    // Combinational so the request cycle itself already stalls.
    assign freeze = ((state_q == IDLE) && req)
                  || (state_q == LO)
                  || (state_q == HI);

    assign ready          = ready_q;
    assign mem_read_value = rdata_q;
    assign SRAM_ADDR      = addr_q;
    assign SRAM_DQ_out    = dq_out_q;
    assign SRAM_DQ_oe     = dq_oe_q;
    assign SRAM_WE_N      = we_n_q;
    assign SRAM_OE_N      = oe_n_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            wa_q       <= '0;
            wdata_hi_q <= '0;
            wr_q       <= 1'b0;
            ready_q    <= 1'b0;
            rdata_q    <= '0;
            addr_q     <= '0;
            dq_out_q   <= '0;
            dq_oe_q    <= 1'b0;
            we_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
        end else begin
            ready_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (req) begin
                        wa_q       <= wa_in;
                        wdata_hi_q <= Val_Rm[31:16];
                        wr_q       <= wr_in;
                        cnt_q      <= '0;
                        addr_q     <= {wa_in, 1'b0};
                        dq_out_q   <= Val_Rm[15:0];
                        dq_oe_q    <= wr_in;
                        we_n_q     <= ~wr_in;
                        oe_n_q     <= wr_in;
                        state_q    <= LO;
                    end
                end
                LO: begin
                    if (last) begin
                        cnt_q    <= '0;
                        addr_q   <= {wa_q, 1'b1};
                        dq_out_q <= wdata_hi_q;
                        if (!wr_q) begin
                            rdata_q[15:0] <= SRAM_DQ_in;
                        end
                        state_q  <= HI;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                HI: begin
                    if (last) begin
                        cnt_q   <= '0;
                        ready_q <= 1'b1;
                        dq_oe_q <= 1'b0;
                        we_n_q  <= 1'b1;
                        oe_n_q  <= 1'b1;
                        if (!wr_q) begin
                            rdata_q[31:16] <= SRAM_DQ_in;
                        end
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef MEM_STAGE_PERF_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
        end else if (freeze) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage placed directly downstream of the execute stage. It consumes the execute stage's ALU result as a byte address, the Rm operand as store data, and the memory read/write enables. It performs one 32-bit load or store as two sequential 16-bit accesses on an external SRAM-style bus with programmable wait states. While the access is in progress it asserts `freeze` to stall the pipeline, and it presents the loaded word to write-back.

## Interface
- `WAIT_CYCLES`, default 2: extra cycles each half-word phase is held; 0 is legal.
- `ADDR_OFFSET`, default 1024: byte base subtracted from `ALU_result` before addressing.
- `clk`  in  1  the single clock; every state element is rising-edge.
- `rst`  in  1  asynchronous, active-low reset.
- `MEM_R_EN`  in  1  load request, from the EXE/MEM register.
- `MEM_W_EN`  in  1  store request.
- `ALU_result`  in  32  byte address.
- `Val_Rm`  in  32  store data.
- `freeze`  out  1  pipeline stall, high while an access is incomplete.
- `ready`  out  1  one-cycle pulse marking access completion.
- `mem_read_value`  out  32  last completed load data, held between loads.
- `SRAM_ADDR`  out  18  half-word address.
- `SRAM_DQ_out`  out  16  write data.
- `SRAM_DQ_oe`  out  1  write-data drive enable.
- `SRAM_DQ_in`  in  16  read data.
- `SRAM_WE_N`, `SRAM_OE_N`  out  1 each  active-low write and output enables.
- `stall_cnt`  out  32  stall-cycle count (see Configuration).

## Operation
- Request signal: `req = MEM_R_EN | MEM_W_EN`. If both enables are high, the access is treated as a write.
- Word address: `wa = (ALU_result - ADDR_OFFSET) >> 2`, truncated to 17 bits.
  - Low phase: `SRAM_ADDR = {wa, 1'b0}`.
  - High phase: `SRAM_ADDR = {wa, 1'b1}`.
  - Bits [1:0] of the address are ignored.
- The FSM has four states: IDLE, LO, HI, DONE.
  - IDLE: when `req` is high, latch the address, data and direction, clear the wait counter, and go to LO. Otherwise stay in IDLE.
  - LO: the counter increments each cycle. When the counter equals `WAIT_CYCLES`, clear it and go to HI.
  - HI: same counting rule; when the counter equals `WAIT_CYCLES`, go to DONE.
  - DONE: `ready=1` and `freeze=0`; go to IDLE unconditionally.
- `freeze = (IDLE & req) | LO | HI`. This is combinational so the request cycle itself stalls.
- Bus behaviour during a write in LO/HI:
  - `SRAM_WE_N=0` and `SRAM_DQ_oe=1`.
  - `SRAM_DQ_out` carries `Val_Rm[15:0]` in LO and `Val_Rm[31:16]` in HI, taken from the latched copy.
- Bus behaviour during a read in LO/HI:
  - `SRAM_OE_N=0`.
  - `SRAM_DQ_in` is captured on the last cycle of LO into `mem_read_value[15:0]` and on the last cycle of HI into `[31:16]`.
- Outside LO/HI: `SRAM_WE_N=1`, `SRAM_OE_N=1`, `SRAM_DQ_oe=0`, and `SRAM_ADDR` holds its last value.
- A write never alters `mem_read_value`.

## Timing
- Reset values:
  - state IDLE, counter 0.
  - `mem_read_value=0`, `SRAM_ADDR=0`, `SRAM_DQ_out=0`, `stall_cnt=0`.
  - `ready=0`, `SRAM_DQ_oe=0`, `SRAM_WE_N=1`, `SRAM_OE_N=1`.
  - `freeze` follows its equation, so it is 0 unless `req` is high.
- Latency is fixed at N = 2·(`WAIT_CYCLES`+1) + 1 cycles per access.
  - With the request first seen in cycle 0, LO occupies cycles 1..W+1, HI occupies W+2..2W+2, and DONE is cycle 2W+3.
  - `freeze` is high in cycles 0..2W+2 and low in DONE.
  - The pipeline register advances at the end of DONE.
- The inputs must be held stable until DONE; the stalled EXE/MEM register guarantees this.
- Back-to-back accesses: the next instruction's request is seen in IDLE the cycle after DONE. There is no extra bubble.
- Reset asserted mid-access: the FSM returns to IDLE immediately and the bus is released asynchronously. The partial access is abandoned and `mem_read_value` is cleared.
- With no request: the block stays idle with zero stall.

## Configuration
- `MEM_STAGE_PERF_CNT_EN` defined:
  - `stall_cnt` increments by 1 on every rising edge where `freeze=1`.
  - It wraps from 0xFFFFFFFF to 0 and is cleared by reset.
- Not defined: `stall_cnt` is tied to 0 and the counter is not synthesized.

## Test plan
- Store with `WAIT_CYCLES`=2, `ALU_result`=1028, `Val_Rm`=0xDEADBEEF:
  - `SRAM_ADDR`=2 with DQ 0xBEEF for 3 cycles, then `SRAM_ADDR`=3 with DQ 0xDEAD for 3 cycles, `SRAM_WE_N` low throughout.
  - `freeze` high for 7 cycles; `ready` pulses in cycle 7.
- Load from 1028 with the SRAM model preloaded as above: `mem_read_value`=0xDEADBEEF on `ready`, held through a following store.
- Idle, `MEM_R_EN`=`MEM_W_EN`=0 for 10 cycles: `freeze`=0, `ready`=0, `SRAM_OE_N`=`SRAM_WE_N`=1.
- Both enables high: behaves as a store (`SRAM_WE_N` low, `SRAM_OE_N` high).
- Reset pulled low during HI of a load: IDLE, `SRAM_OE_N`=1 and `mem_read_value`=0 immediately. After release, the next load completes normally.
- `WAIT_CYCLES`=0, two back-to-back loads:
  - `freeze` pattern 1,1,1,0,1,1,1,0.
  - With the macro defined, `stall_cnt`=6.
